// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART receive port.
// Optional parity support is selected by the UART_RX_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int unsigned ST_VALID   = 0;
    localparam int unsigned ST_OVR     = 1;
    localparam int unsigned ST_FERR    = 2;
    localparam int unsigned ST_PERR    = 3;
    localparam int unsigned ST_CNT_LSB = 8;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty; DEPTH must be a power of 2.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nx;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees its slot this cycle, so a full FIFO still takes a simultaneous push.
    assign w_do_pop  = pop && !r_empty;
    assign w_do_push = push && (!r_full || w_do_pop);

    always_comb begin
        w_count_nx = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nx = r_count + CW'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_nx = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nx;
            r_full  <= (w_count_nx == CW'(DEPTH));
            r_empty <= (w_count_nx == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= din;
    end

    assign dout  = r_mem[r_rptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;

endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receiver: serial deserialiser, receive FIFO, status word, level irq.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_port
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        re,
    input  logic        addr,
    output logic [31:0] rdata,
    output logic        irq
);
    localparam int unsigned BCW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BCW-1:0] BC_HALF = BCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BCW-1:0] BC_FULL = BCW'(CLKS_PER_BIT - 1);

    logic            r_rx_meta;
    logic            r_rx_s;
    rx_state_e       r_state,   w_state_nx;
    logic [BCW-1:0]  r_bc,      w_bc_nx;
    logic [2:0]      r_bit_idx, w_bit_idx_nx;
    logic [7:0]      r_shift,   w_shift_nx;
    logic            r_armed,   w_armed_nx;
    logic            w_push;
    logic            w_ferr_set;
    logic            r_ovr;
    logic            r_ferr;
`ifdef UART_RX_PARITY_EN
    logic            r_perr;
    logic            w_perr_set;
    logic            r_par_bad, w_par_bad_nx;
`endif
    logic [31:0]     r_rdata;
    logic            r_irq;
    logic [31:0]     w_status;
    logic            w_pop;
    logic            w_stat_rd;
    logic            w_ovr_set;
    logic [7:0]      w_dout;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_shift),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Receive FSM; bc counts clocks within the current bit, samples land mid-bit.
    always_comb begin
        w_state_nx   = r_state;
        w_bc_nx      = r_bc;
        w_bit_idx_nx = r_bit_idx;
        w_shift_nx   = r_shift;
        w_armed_nx   = r_armed;
        w_push       = 1'b0;
        w_ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_set   = 1'b0;
        w_par_bad_nx = r_par_bad;
`endif
        case (r_state)
            IDLE: begin
                if (r_rx_s) begin
                    w_armed_nx = 1'b1;
                end else if (r_armed) begin
                    w_state_nx = START;
                    w_bc_nx    = '0;
                end
            end
            START: begin
                if (r_bc == BC_HALF) begin
                    w_bc_nx = '0;
                    if (!r_rx_s) begin
                        w_state_nx   = DATA;
                        w_bit_idx_nx = 3'd0;
`ifdef UART_RX_PARITY_EN
                        w_par_bad_nx = 1'b0;
`endif
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_bc_nx = r_bc + BCW'(1);
                end
            end
            DATA: begin
                if (r_bc == BC_FULL) begin
                    w_bc_nx    = '0;
                    w_shift_nx = {r_rx_s, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nx = PARITY;
`else
                        w_state_nx = STOP;
`endif
                    end else begin
                        w_bit_idx_nx = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_bc_nx = r_bc + BCW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_bc == BC_FULL) begin
                    w_bc_nx    = '0;
                    w_state_nx = STOP;
                    if ((^r_shift) != r_rx_s) begin
                        w_par_bad_nx = 1'b1;
                        w_perr_set   = 1'b1;
                    end
                end else begin
                    w_bc_nx = r_bc + BCW'(1);
                end
            end
`endif
            STOP: begin
                if (r_bc == BC_FULL) begin
                    w_bc_nx    = '0;
                    w_state_nx = IDLE;
                    if (r_rx_s) begin
`ifdef UART_RX_PARITY_EN
                        w_push = !r_par_bad;
`else
                        w_push = 1'b1;
`endif
                        w_armed_nx = 1'b1;
                    end else begin
                        // Disarm so a held-low break cannot look like a new start bit.
                        w_ferr_set = 1'b1;
                        w_armed_nx = 1'b0;
                    end
                end else begin
                    w_bc_nx = r_bc + BCW'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_armed_nx = 1'b0;
            end
        endcase
    end

    assign w_pop     = re && (addr == ADDR_DATA) && !w_empty;
    assign w_stat_rd = re && (addr == ADDR_STATUS);
    assign w_ovr_set = w_push && w_full && !w_pop;

    always_comb begin
        w_status                     = '0;
        w_status[ST_VALID]           = !w_empty;
        w_status[ST_OVR]             = r_ovr;
        w_status[ST_FERR]            = r_ferr;
`ifdef UART_RX_PARITY_EN
        w_status[ST_PERR]            = r_perr;
`else
        w_status[ST_PERR]            = 1'b0;
`endif
        w_status[ST_CNT_LSB +: 8]    = 8'(w_count);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= IDLE;
            r_bc      <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_armed   <= 1'b0;
            r_ovr     <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr    <= 1'b0;
            r_par_bad <= 1'b0;
`endif
            r_rdata   <= 32'd0;
            r_irq     <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_state_nx;
            r_bc      <= w_bc_nx;
            r_bit_idx <= w_bit_idx_nx;
            r_shift   <= w_shift_nx;
            r_armed   <= w_armed_nx;
            // Sticky flags: a new event in the same cycle as a status read survives the clear.
            r_ovr     <= w_ovr_set  | (r_ovr  & ~w_stat_rd);
            r_ferr    <= w_ferr_set | (r_ferr & ~w_stat_rd);
`ifdef UART_RX_PARITY_EN
            r_perr    <= w_perr_set | (r_perr & ~w_stat_rd);
            r_par_bad <= w_par_bad_nx;
`endif
            if (re) begin
                if (addr == ADDR_STATUS) r_rdata <= w_status;
                else                     r_rdata <= w_empty ? 32'd0 : {24'd0, w_dout};
            end
            r_irq <= !w_empty;
        end
    end

    assign rdata = r_rdata;
    assign irq   = r_irq;

endmodule

// File: tb/tb_uart_rx_port.sv
// Self-checking bench for uart_rx_port with a serial line model and a byte scoreboard.
module tb_uart_rx_port;
    import uart_pkg::*;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx    = 1'b1;
    logic        re    = 1'b0;
    logic        addr  = 1'b0;
    logic [31:0] rdata;
    logic        irq;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  sb [$];
    logic [31:0] d;
    logic [31:0] exp32;
`ifdef UART_RX_PARITY_EN
    logic        bad_par = 1'b0;
`endif

    uart_rx_port #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .re    (re),
        .addr  (addr),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Drives one frame starting at a falling clock edge; returns at the falling edge after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ bad_par;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic read_reg(input logic a, output logic [31:0] v);
        re   = 1'b1;
        addr = a;
        @(posedge clk);
        #1;
        v = rdata;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'd0); end
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
        read_reg(ADDR_STATUS, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL reset_status got=%h exp=%h", d, 32'd0); end
    endtask

    task automatic test_single();
        send_frame(8'h41, 1'b1);
        sb.push_back(8'h41);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL single_irq_high got=%b exp=1", irq); end
        read_reg(ADDR_DATA, d);
        exp32 = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'hDEAD_BEEF;
        n_cmp++;
        if (d !== exp32) begin n_err++; $display("FAIL single_data got=%h exp=%h", d, exp32); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL single_irq_low got=%b exp=0", irq); end
        @(negedge clk);
        read_reg(ADDR_STATUS, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL single_status got=%h exp=%h", d, 32'd0); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL glitch_irq got=%b exp=0", irq); end
        read_reg(ADDR_STATUS, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL glitch_status got=%h exp=%h", d, 32'd0); end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1);
            if (i <= 8) sb.push_back(8'(i));
        end
        repeat (4) @(negedge clk);
        read_reg(ADDR_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0803) begin n_err++; $display("FAIL ovr_status got=%h exp=%h", d, 32'h0000_0803); end
        for (int i = 0; i < 8; i++) begin
            read_reg(ADDR_DATA, d);
            exp32 = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'hDEAD_BEEF;
            n_cmp++;
            if (d !== exp32) begin n_err++; $display("FAIL ovr_data[%0d] got=%h exp=%h", i, d, exp32); end
        end
        read_reg(ADDR_DATA, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL ovr_empty_read got=%h exp=%h", d, 32'd0); end
        read_reg(ADDR_STATUS, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL ovr_status2 got=%h exp=%h", d, 32'd0); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        read_reg(ADDR_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0004) begin n_err++; $display("FAIL ferr_status got=%h exp=%h", d, 32'h0000_0004); end
        send_frame(8'hA5, 1'b1);
        sb.push_back(8'hA5);
        repeat (4) @(negedge clk);
        read_reg(ADDR_DATA, d);
        exp32 = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'hDEAD_BEEF;
        n_cmp++;
        if (d !== exp32) begin n_err++; $display("FAIL ferr_next_data got=%h exp=%h", d, exp32); end
        read_reg(ADDR_STATUS, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL ferr_status2 got=%h exp=%h", d, 32'd0); end
    endtask

    task automatic test_full_collision();
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1);
            sb.push_back(8'h10 + 8'(i));
        end
        repeat (4) @(negedge clk);
        read_reg(ADDR_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0801) begin n_err++; $display("FAIL coll_full_status got=%h exp=%h", d, 32'h0000_0801); end
        // The read edge right after the stop bit is the edge on which the receiver pushes.
        send_frame(8'h99, 1'b1);
        read_reg(ADDR_DATA, d);
        exp32 = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'hDEAD_BEEF;
        sb.push_back(8'h99);
        n_cmp++;
        if (d !== exp32) begin n_err++; $display("FAIL coll_data got=%h exp=%h", d, exp32); end
        repeat (4) @(negedge clk);
        read_reg(ADDR_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0801) begin n_err++; $display("FAIL coll_status got=%h exp=%h", d, 32'h0000_0801); end
        for (int i = 0; i < 8; i++) begin
            read_reg(ADDR_DATA, d);
            exp32 = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'hDEAD_BEEF;
            n_cmp++;
            if (d !== exp32) begin n_err++; $display("FAIL coll_drain[%0d] got=%h exp=%h", i, d, exp32); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b  = 8'h3C;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL rstmid_irq got=%b exp=0", irq); end
        read_reg(ADDR_STATUS, d);
        n_cmp++;
        if (d !== 32'd0) begin n_err++; $display("FAIL rstmid_status got=%h exp=%h", d, 32'd0); end
        send_frame(8'h7E, 1'b1);
        sb.push_back(8'h7E);
        repeat (4) @(negedge clk);
        read_reg(ADDR_DATA, d);
        exp32 = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'hDEAD_BEEF;
        n_cmp++;
        if (d !== exp32) begin n_err++; $display("FAIL rstmid_data got=%h exp=%h", d, exp32); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        bad_par = 1'b1;
        send_frame(8'h03, 1'b1);
        bad_par = 1'b0;
        repeat (4) @(negedge clk);
        read_reg(ADDR_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0008) begin n_err++; $display("FAIL par_status got=%h exp=%h", d, 32'h0000_0008); end
        send_frame(8'h03, 1'b1);
        sb.push_back(8'h03);
        repeat (4) @(negedge clk);
        read_reg(ADDR_DATA, d);
        exp32 = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'hDEAD_BEEF;
        n_cmp++;
        if (d !== exp32) begin n_err++; $display("FAIL par_good_data got=%h exp=%h", d, exp32); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_glitch();
        test_overrun();
        test_frame_err();
        test_full_collision();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
